// File: rtl/vend_change_dispenser_if.sv
// rtl/vend_change_dispenser_if.sv - refund handshake, hopper and display signals of the change dispenser
//
// Signals:
//   refund_valid, refund_amount[7:0], refund_ready : refund request handshake from the vending controller
//   hopper_ack, empty_10                           : coin hopper status
//   coin_10, coin_5                                : one-coin eject pulses to the hopper
//   done, error, remaining[7:0]                    : completion pulse, sticky fault, amount still owed
//   DIGIT[3:0], DISPLAY[7:0]                       : active-low two-digit seven-segment scan
// Modports: master = controller/hopper/display side, slave = dispenser side.
interface vend_change_dispenser_if;
  logic       refund_valid;
  logic [7:0] refund_amount;
  logic       refund_ready;
  logic       hopper_ack;
  logic       empty_10;
  logic       coin_10;
  logic       coin_5;
  logic       done;
  logic       error;
  logic [7:0] remaining;
  logic [3:0] DIGIT;
  logic [7:0] DISPLAY;

  modport master (
    output refund_valid, refund_amount, hopper_ack, empty_10,
    input  refund_ready, coin_10, coin_5, done, error, remaining, DIGIT, DISPLAY
  );

  modport slave (
    input  refund_valid, refund_amount, hopper_ack, empty_10,
    output refund_ready, coin_10, coin_5, done, error, remaining, DIGIT, DISPLAY
  );
endinterface

// File: rtl/vend_change_dispenser.sv
// rtl/vend_change_dispenser.sv - pays a refund out as 10/5-unit coins and shows the amount still owed
//
// Parameters:
//   PULSE_CYCLES : cycles each coin line is held high (>=1)
//   ACK_TIMEOUT  : WAIT_ACK cycles without hopper_ack before a fault (1..65535)
//   REFRESH_BITS : width of the free-running display scan counter
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : vend_change_dispenser_if.slave (refund handshake, hopper, status, display)
module vend_change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 255,
  parameter int REFRESH_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vend_change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, WAIT_ACK, DONE, ERROR} state_t;

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  state_t                  state, state_d;
  logic [PW-1:0]           pulse_cnt, pulse_cnt_d;
  logic [15:0]             ack_cnt, ack_cnt_d;
  logic [REFRESH_BITS-1:0] scan_cnt, scan_cnt_d;
  logic                    coin_is_10, coin_is_10_d;
  logic                    refund_ready_q, refund_ready_d;
  logic                    coin_10_q, coin_10_d;
  logic                    coin_5_q, coin_5_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [7:0]              remaining_q, remaining_d;
  logic [3:0]              digit_q, digit_d;
  logic [7:0]              display_q, display_d;
  logic                    amount_legal;
  logic [3:0]              tens, units;

  assign amount_legal = (bus.refund_amount <= 8'd50) &&
                        ((bus.refund_amount % 8'd5) == 8'd0);

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Next-state and next-output logic; every output is the register of its _d value.
  always_comb begin
    state_d      = state;
    pulse_cnt_d  = pulse_cnt;
    ack_cnt_d    = '0;
    coin_is_10_d = coin_is_10;
    remaining_d  = remaining_q;
    error_d      = error_q;
    done_d       = 1'b0;
    coin_10_d    = 1'b0;
    coin_5_d     = 1'b0;
    scan_cnt_d   = scan_cnt + REFRESH_BITS'(1);
    case (state)
      IDLE: begin
        if (bus.refund_valid) begin
          if (amount_legal) begin
            remaining_d = bus.refund_amount;
            error_d     = 1'b0;
            state_d     = SELECT;
          end else begin
            remaining_d = 8'd0;
            error_d     = 1'b1;
            state_d     = ERROR;
          end
        end
      end
      SELECT: begin
        if (remaining_q == 8'd0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          // A 10 is only chosen when at least 10 is owed, so remaining cannot underflow.
          coin_is_10_d = (remaining_q >= 8'd10) && !bus.empty_10;
          coin_10_d    = coin_is_10_d;
          coin_5_d     = !coin_is_10_d;
          pulse_cnt_d  = '0;
          state_d      = PULSE;
        end
      end
      PULSE: begin
        if (pulse_cnt == PW'(PULSE_CYCLES - 1)) begin
          state_d = WAIT_ACK;
        end else begin
          pulse_cnt_d = pulse_cnt + PW'(1);
          coin_10_d   = coin_is_10;
          coin_5_d    = !coin_is_10;
        end
      end
      WAIT_ACK: begin
        if (bus.hopper_ack) begin
          remaining_d = remaining_q - (coin_is_10 ? 8'd10 : 8'd5);
          state_d     = SELECT;
        end else if (ack_cnt == 16'(ACK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ERROR;
        end else begin
          ack_cnt_d = ack_cnt + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    refund_ready_d = (state_d == IDLE);
  end

  // Digits are derived from the next remaining value so the registered display
  // always matches the registered remaining in the same cycle.
  always_comb begin
    if (remaining_d >= 8'd50)      tens = 4'd5;
    else if (remaining_d >= 8'd40) tens = 4'd4;
    else if (remaining_d >= 8'd30) tens = 4'd3;
    else if (remaining_d >= 8'd20) tens = 4'd2;
    else if (remaining_d >= 8'd10) tens = 4'd1;
    else                           tens = 4'd0;
    units = 4'(remaining_d - 8'(tens) * 8'd10);
    if (!scan_cnt_d[REFRESH_BITS-1]) begin
      digit_d   = 4'b1110;
      display_d = seg7(units);
    end else begin
      digit_d   = 4'b1101;
      display_d = (tens == 4'd0) ? 8'hFF : seg7(tens);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pulse_cnt      <= '0;
      ack_cnt        <= '0;
      scan_cnt       <= '0;
      coin_is_10     <= 1'b0;
      refund_ready_q <= 1'b1;
      coin_10_q      <= 1'b0;
      coin_5_q       <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      remaining_q    <= 8'd0;
      digit_q        <= 4'b1111;
      display_q      <= 8'hFF;
    end else begin
      state          <= state_d;
      pulse_cnt      <= pulse_cnt_d;
      ack_cnt        <= ack_cnt_d;
      scan_cnt       <= scan_cnt_d;
      coin_is_10     <= coin_is_10_d;
      refund_ready_q <= refund_ready_d;
      coin_10_q      <= coin_10_d;
      coin_5_q       <= coin_5_d;
      done_q         <= done_d;
      error_q        <= error_d;
      remaining_q    <= remaining_d;
      digit_q        <= digit_d;
      display_q      <= display_d;
    end
  end

  assign bus.refund_ready = refund_ready_q;
  assign bus.coin_10      = coin_10_q;
  assign bus.coin_5       = coin_5_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.remaining    = remaining_q;
  assign bus.DIGIT        = digit_q;
  assign bus.DISPLAY      = display_q;

endmodule

// File: doc/vend_change_dispenser.md
# vend_change_dispenser

Change-return unit for the vending-machine datapath. It accepts a refund amount from the vending controller over a valid/ready handshake and pays it out as 10- and 5-unit coins to the coin hopper, one coin per pulse/acknowledge cycle. It also shows the amount still owed on two seven-segment digits. It is the pay-out counterpart of the coin-acceptance FSM: that FSM takes money in, this block hands it back.

## Interface
- PULSE_CYCLES, 4: cycles each coin line is held high (≥1).
- ACK_TIMEOUT, 255: WAIT_ACK cycles without hopper_ack before error (≥1, ≤65535).
- REFRESH_BITS, 16: width of free-running display scan counter.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- refund_valid  in  1  controller presents a refund.
- refund_amount  in  8  refund value, unsigned; legal = multiple of 5, 0..50.
- refund_ready  out  1  high only in IDLE.
- hopper_ack  in  1  hopper confirms one coin dropped.
- empty_10  in  1  10-unit tube empty; pay with 5s.
- coin_10  out  1  eject one 10-unit coin.
- coin_5  out  1  eject one 5-unit coin.
- done  out  1  one-cycle pulse, refund fully paid.
- error  out  1  sticky fault flag.
- remaining  out  8  amount still owed.
- DIGIT  out  4  active-low digit select.
- DISPLAY  out  8  active-low segments {dp,g,f,e,d,c,b,a}.

## Operation
- States: IDLE, SELECT, PULSE, WAIT_ACK, DONE, ERROR.
- IDLE: refund_ready=1. When refund_valid=1:
  - Legal amount: load remaining, clear error, go to SELECT.
  - Illegal amount (not a multiple of 5, or >50): set error, leave remaining at 0, go to ERROR.
- refund_valid is ignored outside IDLE.
- SELECT, with remaining==0: go to DONE.
- SELECT, otherwise: latch coin = 10 if remaining≥10 and empty_10==0, else 5. Go to PULSE. empty_10 is sampled only in SELECT.
- PULSE: the latched coin line is high for exactly PULSE_CYCLES cycles, then go to WAIT_ACK. coin_10 and coin_5 are never high together.
- WAIT_ACK, hopper_ack=1: remaining -= coin value, timeout counter clears, go to SELECT.
- WAIT_ACK, no ack for ACK_TIMEOUT consecutive cycles: set error, go to ERROR. remaining keeps the undelivered value.
- hopper_ack outside WAIT_ACK is ignored.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: one cycle, then IDLE. error stays high until the next legal request is accepted.
- Amount 0 (legal): IDLE → SELECT → DONE, no coins.
- Arithmetic: 8-bit unsigned. remaining never underflows, because a 10-coin is chosen only when remaining≥10.
- Display:
  - A scan counter increments every clk. Its MSB selects the digit.
  - MSB=0: DIGIT=4'b1110, units digit of remaining.
  - MSB=1: DIGIT=4'b1101, tens digit of remaining. Blanked (DISPLAY=8'hFF) when tens=0.
  - dp is always off.
  - Decimal digits come from remaining via divide-by-10 logic (values 0..50).

## Timing
- All outputs are registered.
- Reset values: refund_ready=1, coin_10=0, coin_5=0, done=0, error=0, remaining=0, DIGIT=4'b1111, DISPLAY=8'hFF. State=IDLE; scan and timeout counters = 0.
- Request accepted on edge T (IDLE, refund_valid=1). SELECT during T+1. Coin line high during cycles T+2 … T+1+PULSE_CYCLES.
- An ack sampled at edge A updates remaining at A; the next coin pulse starts two cycles later.
- Per coin with immediate ack: PULSE_CYCLES+2 cycles.
- done asserts in the cycle after SELECT sees remaining==0. refund_ready returns the cycle after that.
- Reset mid-operation: the coin line drops immediately (asynchronous), remaining clears, no done pulse. The controller must reissue the refund.

## Test plan
- Amount 35, empty_10=0, ack 1 cycle into each WAIT_ACK → coins 10,10,10,5. remaining 35→25→15→5→0. One done pulse. error=0.
- Amount 30, empty_10=1 → six coin_5 pulses, each PULSE_CYCLES wide, no coin_10. done once.
- Amount 0 → done two cycles after accept, no coin pulses. Amount 37 → error=1, no coins, back to IDLE. A following legal 5 clears error.
- Amount 20, hopper_ack never asserted → a single coin_10 pulse, error after ACK_TIMEOUT WAIT_ACK cycles, remaining=20, refund_ready=1 again.
- Assert rst_n=0 during a PULSE of amount 50 → coin line 0 asynchronously, all outputs at reset values. refund_valid pulses while busy → ignored, no change in coin count.
- Display with remaining=45 → DIGIT 1110 shows "5" (DISPLAY=8'b10010010), DIGIT 1101 shows "4" (8'b10011001). With remaining=5, the tens digit is blank (8'hFF).
